// File: rtl/instruction_write_back_pkg.sv
// Shared definitions for the write-back stage: FSM encoding, CPSR flag positions,
// the PC register index and the multiply flag helper.
package instruction_write_back_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 4;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_HI   = 1'b1
    } wb_state_e;

    localparam int CPSR_N = 31;
    localparam int CPSR_Z = 30;
    localparam int CPSR_C = 29;
    localparam int CPSR_V = 28;

    localparam int PC_REG = 15;

    // New CPSR after a multiply: N/Z from the result, C/V and the low bits kept.
    function automatic logic [31:0] mul_cpsr(input logic [63:0] m_result,
                                             input logic        m_long,
                                             input logic [31:0] cpsr);
        logic [31:0] next;
        next         = cpsr;
        next[CPSR_N] = m_long ? m_result[63] : m_result[31];
        next[CPSR_Z] = m_long ? (m_result == 64'd0) : (m_result[31:0] == 32'd0);
        return next;
    endfunction

endpackage

// File: rtl/instruction_write_back.sv
// Final pipeline stage: drives the register file write port and the CPSR write.
// Long multiplies take two beats (RdLo, then RdHi) and stall upstream in between.
module instruction_write_back
    import instruction_write_back_pkg::*;
#(
    parameter int DATA_WIDTH     = instruction_write_back_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = instruction_write_back_pkg::REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wb_i,
    input  logic [REG_ADDR_WIDTH-1:0] dest_i,
    input  logic [REG_ADDR_WIDTH-1:0] dest_hi_i,
    input  logic                      write_dest_do_i,
    input  logic                      write_dest_m_i,
    input  logic                      m_long_i,
    input  logic                      write_cpsr_i,
    input  logic [DATA_WIDTH-1:0]     result_i,
    input  logic [3:0]                flags_i,
    input  logic [2*DATA_WIDTH-1:0]   m_result_i,
    input  logic [31:0]               cpsr_i,
    output logic                      reg_we_o,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr_o,
    output logic [DATA_WIDTH-1:0]     reg_data_o,
    output logic                      cpsr_we_o,
    output logic [31:0]               cpsr_o,
    output logic                      pc_write_o,
    output logic                      stall_o
);

    localparam logic [REG_ADDR_WIDTH-1:0] PC_ADDR = REG_ADDR_WIDTH'(PC_REG);

    wb_state_e                 state_q;
    logic                      reg_we_q;
    logic [REG_ADDR_WIDTH-1:0] reg_addr_q;
    logic [DATA_WIDTH-1:0]     reg_data_q;
    logic                      cpsr_we_q;
    logic [31:0]               cpsr_q;
    logic                      pc_write_q;
    logic                      stall_q;
    logic [REG_ADDR_WIDTH-1:0] hi_addr_q;
    logic [DATA_WIDTH-1:0]     hi_data_q;

    logic                      mul_only_d;
    logic                      is_long_d;
    logic                      do_write_d;
    logic [DATA_WIDTH-1:0]     lo_data_d;
    logic [31:0]               cpsr_d;

    // Data op wins when both write flags are set, so multiply flags only apply to a pure multiply.
    always_comb begin
        mul_only_d = write_dest_m_i && !write_dest_do_i;
        is_long_d  = mul_only_d && m_long_i;
        do_write_d = write_dest_do_i || write_dest_m_i;
        lo_data_d  = write_dest_do_i ? result_i : m_result_i[DATA_WIDTH-1:0];
        cpsr_d     = {flags_i, cpsr_i[27:0]};
        if (mul_only_d) begin
            cpsr_d = mul_cpsr(64'(m_result_i), m_long_i, cpsr_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WB_IDLE;
            reg_we_q   <= 1'b0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            cpsr_we_q  <= 1'b0;
            cpsr_q     <= '0;
            pc_write_q <= 1'b0;
            stall_q    <= 1'b0;
            hi_addr_q  <= '0;
            hi_data_q  <= '0;
        end else begin
            reg_we_q   <= 1'b0;
            cpsr_we_q  <= 1'b0;
            pc_write_q <= 1'b0;
            stall_q    <= 1'b0;
            case (state_q)
                WB_IDLE: begin
                    if (wb_i) begin
                        if (do_write_d) begin
                            reg_we_q   <= 1'b1;
                            reg_addr_q <= dest_i;
                            reg_data_q <= lo_data_d;
                            pc_write_q <= (dest_i == PC_ADDR);
                        end
                        if (write_cpsr_i) begin
                            cpsr_we_q <= 1'b1;
                            cpsr_q    <= cpsr_d;
                        end
                        if (is_long_d) begin
                            hi_addr_q <= dest_hi_i;
                            hi_data_q <= m_result_i[2*DATA_WIDTH-1:DATA_WIDTH];
                            stall_q   <= 1'b1;
                            state_q   <= WB_HI;
                        end
                    end
                end
                WB_HI: begin
                    // Second beat of a long multiply; wb_i is held off by stall_o.
                    reg_we_q   <= 1'b1;
                    reg_addr_q <= hi_addr_q;
                    reg_data_q <= hi_data_q;
                    pc_write_q <= (hi_addr_q == PC_ADDR);
                    state_q    <= WB_IDLE;
                end
                default: state_q <= WB_IDLE;
            endcase
        end
    end

    assign reg_we_o   = reg_we_q;
    assign reg_addr_o = reg_addr_q;
    assign reg_data_o = reg_data_q;
    assign cpsr_we_o  = cpsr_we_q;
    assign cpsr_o     = cpsr_q;
    assign pc_write_o = pc_write_q;
    assign stall_o    = stall_q;

endmodule

// File: tb/tb_instruction_write_back.sv
// Directed and randomized bench for instruction_write_back against a beat-queue reference model.
module tb_instruction_write_back;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_i;
    logic [3:0]  dest_i;
    logic [3:0]  dest_hi_i;
    logic        write_dest_do_i;
    logic        write_dest_m_i;
    logic        m_long_i;
    logic        write_cpsr_i;
    logic [31:0] result_i;
    logic [3:0]  flags_i;
    logic [63:0] m_result_i;
    logic [31:0] cpsr_i;
    logic        reg_we_o;
    logic [3:0]  reg_addr_o;
    logic [31:0] reg_data_o;
    logic        cpsr_we_o;
    logic [31:0] cpsr_o;
    logic        pc_write_o;
    logic        stall_o;

    int checks = 0;
    int errors = 0;

    // Reference model: expected outputs plus a queue of register writes still owed.
    logic        e_we, e_cpsr_we, e_pc, e_stall;
    logic [3:0]  e_addr;
    logic [31:0] e_data, e_cpsr;
    logic [35:0] exp_q[$];

    instruction_write_back dut (
        .clk(clk), .rst(rst), .wb_i(wb_i), .dest_i(dest_i), .dest_hi_i(dest_hi_i),
        .write_dest_do_i(write_dest_do_i), .write_dest_m_i(write_dest_m_i),
        .m_long_i(m_long_i), .write_cpsr_i(write_cpsr_i), .result_i(result_i),
        .flags_i(flags_i), .m_result_i(m_result_i), .cpsr_i(cpsr_i),
        .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o), .reg_data_o(reg_data_o),
        .cpsr_we_o(cpsr_we_o), .cpsr_o(cpsr_o), .pc_write_o(pc_write_o), .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [35:0] beat;
        logic [63:0] full;
        logic        mul_only;
        if (rst) begin
            exp_q.delete();
            e_we = 0; e_cpsr_we = 0; e_stall = 0;
            e_addr = 0; e_data = 0; e_cpsr = 0;
        end else if (exp_q.size() > 0) begin
            beat = exp_q.pop_front();
            e_we = 1; e_addr = beat[35:32]; e_data = beat[31:0];
            e_cpsr_we = 0; e_stall = 0;
        end else if (wb_i) begin
            mul_only = write_dest_m_i && !write_dest_do_i;
            e_we = write_dest_do_i || write_dest_m_i;
            if (e_we) begin
                e_addr = dest_i;
                e_data = write_dest_do_i ? result_i : m_result_i[31:0];
            end
            e_cpsr_we = write_cpsr_i;
            if (write_cpsr_i) begin
                if (mul_only) begin
                    full = m_long_i ? m_result_i : {32'd0, m_result_i[31:0]};
                    e_cpsr = {(m_long_i ? full[63] : full[31]), (full == 64'd0), cpsr_i[29:0]};
                end else begin
                    e_cpsr = {flags_i, cpsr_i[27:0]};
                end
            end
            e_stall = mul_only && m_long_i;
            if (e_stall) exp_q.push_back({dest_hi_i, m_result_i[63:32]});
        end else begin
            e_we = 0; e_cpsr_we = 0; e_stall = 0;
        end
        e_pc = e_we && (e_addr == 4'd15);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_we"},      64'(reg_we_o),   64'(e_we));
        chk({tag, "_addr"},    64'(reg_addr_o), 64'(e_addr));
        chk({tag, "_data"},    64'(reg_data_o), 64'(e_data));
        chk({tag, "_cpsr_we"}, 64'(cpsr_we_o),  64'(e_cpsr_we));
        chk({tag, "_cpsr"},    64'(cpsr_o),     64'(e_cpsr));
        chk({tag, "_pc"},      64'(pc_write_o), 64'(e_pc));
        chk({tag, "_stall"},   64'(stall_o),    64'(e_stall));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic wb, input logic d_o, input logic m, input logic lng,
                         input logic wc, input logic [3:0] dst, input logic [3:0] dst_hi,
                         input logic [31:0] res, input logic [3:0] flg,
                         input logic [63:0] mres, input logic [31:0] cp);
        wb_i = wb; write_dest_do_i = d_o; write_dest_m_i = m; m_long_i = lng;
        write_cpsr_i = wc; dest_i = dst; dest_hi_i = dst_hi; result_i = res;
        flags_i = flg; m_result_i = mres; cpsr_i = cp;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 4'd0, 4'd0, 32'd0, 4'd0, 64'd0, 32'd0);
    endtask

    initial begin
        // Reset with a valid data op presented: reset must dominate.
        rst = 1;
        drive(1, 1, 0, 0, 1, 4'd15, 4'd0, 32'hDEAD, 4'hF, 64'd0, 32'hFFFFFFFF);
        tick("rst0");
        tick("rst1");
        chk("rst_we", 64'(reg_we_o), 64'd0);
        chk("rst_cpsr", 64'(cpsr_o), 64'd0);
        rst = 0;
        idle();
        tick("post_rst");

        // Data op with CPSR update.
        drive(1, 1, 0, 0, 1, 4'd3, 4'd0, 32'h1234, 4'b1001, 64'd0, 32'h000000D3);
        tick("dataop");
        chk("dataop_cpsr_lit", 64'(cpsr_o), 64'h900000D3);
        chk("dataop_data_lit", 64'(reg_data_o), 64'h1234);
        idle();
        tick("dataop_idle");

        // Long multiply; wb_i during the stall cycle must be ignored.
        drive(1, 0, 1, 1, 1, 4'd2, 4'd5, 32'h0, 4'h0, 64'hFFFFFFFF_00000000, 32'h200000D3);
        tick("long_b1");
        chk("long_b1_cpsr_lit", 64'(cpsr_o), 64'hA00000D3);
        chk("long_b1_stall_lit", 64'(stall_o), 64'd1);
        drive(1, 1, 0, 0, 1, 4'd7, 4'd0, 32'hBAD, 4'hF, 64'd0, 32'h0);
        tick("long_b2");
        chk("long_b2_data_lit", 64'(reg_data_o), 64'hFFFFFFFF);
        chk("long_b2_addr_lit", 64'(reg_addr_o), 64'd5);
        idle();
        tick("long_after");

        // Short multiply: Z from low word only; long with same value has Z=0.
        drive(1, 0, 1, 0, 1, 4'd4, 4'd0, 32'h0, 4'h0, 64'h1_00000000, 32'h000000D3);
        tick("short_z");
        chk("short_z_cpsr_lit", 64'(cpsr_o), 64'h400000D3);
        drive(1, 0, 1, 1, 1, 4'd4, 4'd6, 32'h0, 4'h0, 64'h1_00000000, 32'h000000D3);
        tick("long_nz_b1");
        chk("long_nz_cpsr_lit", 64'(cpsr_o), 64'h000000D3);
        idle();
        tick("long_nz_b2");

        // PC writes: data op to r15, then long multiply with RdHi = r15.
        drive(1, 1, 0, 0, 0, 4'd15, 4'd0, 32'h8000, 4'h0, 64'd0, 32'h0);
        tick("pc_do");
        chk("pc_do_lit", 64'(pc_write_o), 64'd1);
        idle();
        tick("pc_do_off");
        drive(1, 0, 1, 1, 0, 4'd1, 4'd15, 32'h0, 4'h0, 64'h0000ABCD_00001111, 32'h0);
        tick("pc_hi_b1");
        chk("pc_hi_b1_lit", 64'(pc_write_o), 64'd0);
        idle();
        tick("pc_hi_b2");
        chk("pc_hi_b2_lit", 64'(pc_write_o), 64'd1);

        // Reset while in HI discards the RdHi write.
        drive(1, 0, 1, 1, 0, 4'd8, 4'd9, 32'h0, 4'h0, 64'h12345678_9ABCDEF0, 32'h0);
        tick("rst_hi_b1");
        idle();
        rst = 1;
        tick("rst_hi");
        chk("rst_hi_we_lit", 64'(reg_we_o), 64'd0);
        rst = 0;
        tick("rst_hi_after");

        // Both write flags: data op wins; same-register long multiply.
        drive(1, 1, 1, 1, 1, 4'd10, 4'd11, 32'hCAFEF00D, 4'b0110, 64'hFFFF0000_11112222, 32'h0);
        tick("both");
        chk("both_data_lit", 64'(reg_data_o), 64'hCAFEF00D);
        drive(1, 0, 1, 1, 0, 4'd12, 4'd12, 32'h0, 4'h0, 64'hAAAA0000_BBBB0000, 32'h0);
        tick("same_b1");
        idle();
        tick("same_b2");
        drive(1, 0, 0, 0, 1, 4'd3, 4'd0, 32'h0, 4'b0011, 64'd0, 32'h0FFFFFFF);
        tick("noflag");

        // Randomized traffic including writes while stalled and occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  4'($urandom_range(12, 15)), 4'($urandom_range(12, 15)), $urandom(),
                  4'($urandom()),
                  ($urandom_range(0, 3) == 0) ? {32'($urandom_range(0, 1)), 32'd0}
                                              : {$urandom(), $urandom()},
                  $urandom());
            tick("rand");
        end
        rst = 0;
        idle();
        tick("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
